// File: rtl/sobel_sched_pkg.sv
// Shared types and constants for the Sobel frame scheduler: FSM state encoding,
// key width, core-reset pulse length and the completion-record layout.
package sobel_sched_pkg;

  localparam int KEY_W     = 6;
  localparam int RST_PULSE = 2;

  // Completion-record field widths; the scheduler's BUF_W/CNT_W must not exceed these.
  localparam int REC_BUF_W = 2;
  localparam int REC_CNT_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    RUN,
    RECOVER,
    CPL
  } sched_state_e;

  typedef struct packed {
    logic [REC_BUF_W-1:0] buf_sel;
    logic [REC_CNT_W-1:0] cycles;
    logic                 err;
  } cpl_rec_t;

endpackage

// File: rtl/sobel_req_fifo.sv
// Frame request queue: synchronous FIFO of buffer selectors with full/empty
// flags and an occupancy level. Head entry is visible on pop_data while non-empty.
module sobel_req_fifo #(
  parameter int QDEPTH = 4,
  parameter int BUF_W  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [BUF_W-1:0]          push_data,
  input  logic                      pop,
  output logic [BUF_W-1:0]          pop_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(QDEPTH):0]   level
);

  localparam int AW = $clog2(QDEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [BUF_W-1:0] mem_q [QDEPTH];
  logic             do_push, do_pop;

  assign full     = (level_q == (AW+1)'(QDEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is deliberately not reset; the level/pointers guarantee stale entries are never read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/sobel_frame_sched.sv
// Frame-level controller for the obfuscated Sobel core: queues requests, launches one
// frame at a time with a stable key, times it and returns completion records.
// Optional watchdog/RECOVER path compiled in with `define SOBEL_SCHED_WDOG_EN.
module sobel_frame_sched
  import sobel_sched_pkg::*;
#(
  parameter int          QDEPTH   = 4,
  parameter int          BUF_W    = 2,
  parameter int          CNT_W    = 32,
  parameter logic [31:0] WDOG_CYC = 32'd600000
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [BUF_W-1:0]         req_buf,
  input  logic                     key_valid,
  input  logic [KEY_W-1:0]         key_in,
  output logic                     core_start,
  input  logic                     core_done,
  input  logic                     core_idle,
  output logic                     core_rst,
  output logic [KEY_W-1:0]         core_key,
  output logic [BUF_W-1:0]         core_buf,
  output logic                     cpl_valid,
  input  logic                     cpl_ready,
  output logic [BUF_W-1:0]         cpl_buf,
  output logic [CNT_W-1:0]         cpl_cycles,
  output logic                     cpl_err,
  output logic                     busy,
  output logic [$clog2(QDEPTH):0]  q_level
);

  logic             fifo_full, fifo_empty, fifo_pop;
  logic [BUF_W-1:0] fifo_head;

  sched_state_e     state_q, state_d;
  logic             core_start_q, core_start_d;
  logic [KEY_W-1:0] core_key_q, core_key_d;
  logic [BUF_W-1:0] core_buf_q, core_buf_d;
  logic [KEY_W-1:0] key_pend_q, key_pend_d;
  logic             pend_flag_q, pend_flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cpl_valid_q, cpl_valid_d;
  cpl_rec_t         cpl_q, cpl_d;

  sobel_req_fifo #(
    .QDEPTH (QDEPTH),
    .BUF_W  (BUF_W)
  ) u_req_fifo (
    .clk       (ap_clk),
    .rst       (ap_rst),
    .push      (req_valid),
    .push_data (req_buf),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (q_level)
  );

`ifdef SOBEL_SCHED_WDOG_EN
  localparam int RC_W = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
  logic [RC_W-1:0] rst_cnt_q, rst_cnt_d;
  logic            core_rst_q, core_rst_d;
`endif

  always_comb begin
    state_d      = state_q;
    core_start_d = 1'b0;
    core_key_d   = core_key_q;
    core_buf_d   = core_buf_q;
    key_pend_d   = key_pend_q;
    pend_flag_d  = pend_flag_q;
    cnt_d        = cnt_q;
    cpl_valid_d  = cpl_valid_q;
    cpl_d        = cpl_q;
    fifo_pop     = 1'b0;
`ifdef SOBEL_SCHED_WDOG_EN
    rst_cnt_d    = rst_cnt_q;
`endif

    if (key_valid) begin
      key_pend_d  = key_in;
      pend_flag_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          core_buf_d = fifo_head;
          state_d    = LAUNCH;
          // The key latched here is frozen for the whole frame; a same-cycle write stays pending.
          if (pend_flag_q) core_key_d = key_pend_q;
          if (!key_valid)  pend_flag_d = 1'b0;
        end
      end
      LAUNCH: begin
        // core_start is registered: ap_idle depends on ap_start, so no combinational path back.
        if (core_idle && !core_start_q) begin
          core_start_d = 1'b1;
          cnt_d        = CNT_W'(1);
          state_d      = RUN;
        end
      end
      RUN: begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        if (core_done) begin
          cpl_d.buf_sel = REC_BUF_W'(core_buf_q);
          cpl_d.cycles  = REC_CNT_W'(cnt_q);
          cpl_d.err     = 1'b0;
          cpl_valid_d   = 1'b1;
          state_d       = CPL;
        end
`ifdef SOBEL_SCHED_WDOG_EN
        else if (cnt_q == CNT_W'(WDOG_CYC)) begin
          rst_cnt_d = '0;
          state_d   = RECOVER;
        end
`endif
      end
`ifdef SOBEL_SCHED_WDOG_EN
      RECOVER: begin
        rst_cnt_d = rst_cnt_q + RC_W'(1);
        if (rst_cnt_q == RC_W'(RST_PULSE - 1)) begin
          cpl_d.buf_sel = REC_BUF_W'(core_buf_q);
          cpl_d.cycles  = REC_CNT_W'(WDOG_CYC);
          cpl_d.err     = 1'b1;
          cpl_valid_d   = 1'b1;
          state_d       = CPL;
        end
      end
`endif
      CPL: begin
        if (cpl_ready) begin
          cpl_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef SOBEL_SCHED_WDOG_EN
    core_rst_d = (state_d == RECOVER);
`endif
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q      <= IDLE;
      core_start_q <= 1'b0;
      core_key_q   <= '0;
      core_buf_q   <= '0;
      key_pend_q   <= '0;
      pend_flag_q  <= 1'b0;
      cnt_q        <= '0;
      cpl_valid_q  <= 1'b0;
      cpl_q        <= '0;
    end else begin
      state_q      <= state_d;
      core_start_q <= core_start_d;
      core_key_q   <= core_key_d;
      core_buf_q   <= core_buf_d;
      key_pend_q   <= key_pend_d;
      pend_flag_q  <= pend_flag_d;
      cnt_q        <= cnt_d;
      cpl_valid_q  <= cpl_valid_d;
      cpl_q        <= cpl_d;
    end
  end

`ifdef SOBEL_SCHED_WDOG_EN
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      rst_cnt_q  <= '0;
      core_rst_q <= 1'b0;
    end else begin
      rst_cnt_q  <= rst_cnt_d;
      core_rst_q <= core_rst_d;
    end
  end

  assign core_rst = core_rst_q;
  assign cpl_err  = cpl_q.err;
`else
  logic wdog_unused;
  assign wdog_unused = ^{WDOG_CYC, cpl_q.err};
  assign core_rst    = 1'b0;
  assign cpl_err     = 1'b0;
`endif

  assign req_ready  = !fifo_full;
  assign core_start = core_start_q;
  assign core_key   = core_key_q;
  assign core_buf   = core_buf_q;
  assign cpl_valid  = cpl_valid_q;
  assign cpl_buf    = BUF_W'(cpl_q.buf_sel);
  assign cpl_cycles = CNT_W'(cpl_q.cycles);
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sobel_frame_sched.sv
// Directed self-checking bench for sobel_frame_sched with a simple core model that
// raises ap_done a programmable number of cycles after ap_start (0 = never).
module tb_sobel_frame_sched;

  localparam int LIMIT = 400;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_buf;
  logic        key_valid;
  logic [5:0]  key_in;
  logic        core_start, core_done, core_idle, core_rst;
  logic [5:0]  core_key;
  logic [1:0]  core_buf;
  logic        cpl_valid, cpl_ready;
  logic [1:0]  cpl_buf;
  logic [31:0] cpl_cycles;
  logic        cpl_err, busy;
  logic [2:0]  q_level;

  int n_checks = 0;
  int n_fail   = 0;

  sobel_frame_sched #(
    .QDEPTH   (4),
    .BUF_W    (2),
    .CNT_W    (32),
    .WDOG_CYC (32'd50)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_buf    (req_buf),
    .key_valid  (key_valid),
    .key_in     (key_in),
    .core_start (core_start),
    .core_done  (core_done),
    .core_idle  (core_idle),
    .core_rst   (core_rst),
    .core_key   (core_key),
    .core_buf   (core_buf),
    .cpl_valid  (cpl_valid),
    .cpl_ready  (cpl_ready),
    .cpl_buf    (cpl_buf),
    .cpl_cycles (cpl_cycles),
    .cpl_err    (cpl_err),
    .busy       (busy),
    .q_level    (q_level)
  );

  always #5 ap_clk = ~ap_clk;

  // Core model: done asserted done_lat cycles after the core_start cycle.
  int done_lat = 100;
  int lat_cur  = 0;
  int run_k    = -1;

  always @(negedge ap_clk) begin
    core_done = 1'b0;
    if (ap_rst || core_rst) begin
      run_k = -1;
    end else if (core_start) begin
      run_k   = 0;
      lat_cur = done_lat;
    end else if (run_k >= 0) begin
      run_k++;
      if (lat_cur > 0 && run_k == lat_cur) begin
        core_done = 1'b1;
        run_k     = -1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge ap_clk);
  endtask

  task automatic push(input logic [1:0] b);
    req_valid = 1'b1;
    req_buf   = b;
    tick();
    req_valid = 1'b0;
  endtask

  // Push one request at the current negedge; n = negedges until core_start is seen.
  task automatic start_frame(input logic [1:0] b, output int n);
    req_valid = 1'b1;
    req_buf   = b;
    n = 0;
    do begin
      tick();
      req_valid = 1'b0;
      n++;
    end while (!core_start && n < LIMIT);
    check("start_seen", core_start, 1'b1);
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (!core_start && n < LIMIT) begin
      tick();
      n++;
    end
    check("start_wait", core_start, 1'b1);
  endtask

  task automatic wait_cpl(output int n);
    n = 0;
    while (!cpl_valid && n < LIMIT) begin
      tick();
      n++;
    end
    check("cpl_wait", cpl_valid, 1'b1);
  endtask

  task automatic accept();
    cpl_ready = 1'b1;
    tick();
    cpl_ready = 1'b0;
  endtask

  initial begin
    int n;
    int seen;
    int rst_hi;
    logic [1:0] bufs [5];
    bufs[0] = 2'd0; bufs[1] = 2'd1; bufs[2] = 2'd2; bufs[3] = 2'd3; bufs[4] = 2'd0;

    ap_rst    = 1'b1;
    req_valid = 1'b0;
    req_buf   = '0;
    key_valid = 1'b0;
    key_in    = '0;
    core_idle = 1'b1;
    cpl_ready = 1'b0;
    repeat (3) tick();

    // Reset values
    check("rst_req_ready",  req_ready,  1'b1);
    check("rst_core_start", core_start, 1'b0);
    check("rst_core_rst",   core_rst,   1'b0);
    check("rst_core_key",   core_key,   6'h00);
    check("rst_core_buf",   core_buf,   2'd0);
    check("rst_cpl_valid",  cpl_valid,  1'b0);
    check("rst_cpl_cycles", cpl_cycles, 32'd0);
    check("rst_cpl_err",    cpl_err,    1'b0);
    check("rst_busy",       busy,       1'b0);
    check("rst_q_level",    q_level,    3'd0);
    ap_rst = 1'b0;
    tick();

    // Single frame, key 2A, done 100 cycles after start
    key_valid = 1'b1;
    key_in    = 6'h2A;
    tick();
    key_valid = 1'b0;
    start_frame(2'd1, n);
    check("t1_start_latency", n, 3);
    check("t1_core_key", core_key, 6'h2A);
    check("t1_core_buf", core_buf, 2'd1);
    check("t1_busy", busy, 1'b1);
    tick();
    check("t1_start_one_cycle", core_start, 1'b0);
    wait_cpl(n);
    check("t1_done_to_cpl", n, 100);
    check("t1_cpl_cycles", cpl_cycles, 32'd101);
    check("t1_cpl_err", cpl_err, 1'b0);
    check("t1_cpl_buf", cpl_buf, 2'd1);
    repeat (3) tick();
    check("t1_cpl_hold_valid", cpl_valid, 1'b1);
    check("t1_cpl_hold_cycles", cpl_cycles, 32'd101);
    accept();
    check("t1_cpl_dropped", cpl_valid, 1'b0);
    check("t1_idle_after_accept", busy, 1'b0);

    // Five back-to-back requests, completions stalled
    done_lat = 5;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_ready_%0d", i), req_ready, 1'b1);
      req_valid = 1'b1;
      req_buf   = bufs[i];
      tick();
    end
    req_valid = 1'b0;
    check("t2_ready_full", req_ready, 1'b0);
    check("t2_level_full", q_level, 3'd4);
    for (int i = 0; i < 5; i++) begin
      wait_cpl(n);
      check($sformatf("t2_cpl_buf_%0d", i), cpl_buf, bufs[i]);
      check($sformatf("t2_cpl_cycles_%0d", i), cpl_cycles, 32'd6);
      accept();
    end
    check("t2_level_empty", q_level, 3'd0);
    check("t2_idle", busy, 1'b0);

    // Key written during RUN applies to the next frame only
    done_lat = 40;
    start_frame(2'd2, n);
    check("t3_a_key", core_key, 6'h2A);
    repeat (4) tick();
    key_valid = 1'b1;
    key_in    = 6'h15;
    tick();
    key_valid = 1'b0;
    push(2'd3);
    check("t3_a_key_held", core_key, 6'h2A);
    wait_cpl(n);
    check("t3_a_cpl_buf", cpl_buf, 2'd2);
    cpl_ready = 1'b1;
    n = 0;
    do begin
      tick();
      cpl_ready = 1'b0;
      n++;
    end while (!core_start && n < LIMIT);
    check("t3_accept_to_start", n, 3);
    check("t3_b_key", core_key, 6'h15);
    check("t3_b_buf", core_buf, 2'd3);
    wait_cpl(n);
    check("t3_b_cpl_buf", cpl_buf, 2'd3);
    accept();

    // Core held non-idle in LAUNCH
    core_idle = 1'b0;
    push(2'd0);
    seen = 0;
    repeat (10) begin
      tick();
      if (core_start) seen++;
    end
    check("t6_no_start_while_busy_core", seen, 0);
    check("t6_busy_in_launch", busy, 1'b1);
    core_idle = 1'b1;
    tick();
    check("t6_start_after_idle", core_start, 1'b1);
    tick();
    check("t6_start_single", core_start, 1'b0);
    wait_cpl(n);
    check("t6_cpl_cycles", cpl_cycles, 32'd41);
    accept();

`ifdef SOBEL_SCHED_WDOG_EN
    // Watchdog: core never finishes frame 0; frame 1 runs normally
    done_lat = 0;
    start_frame(2'd0, n);
    push(2'd1);
    n = 1;
    rst_hi = 0;
    while (!cpl_valid && n < LIMIT) begin
      tick();
      n++;
      if (core_rst) rst_hi++;
    end
    check("t4_cpl_seen", cpl_valid, 1'b1);
    check("t4_start_to_cpl", n, 52);
    check("t4_core_rst_pulse", rst_hi, 2);
    check("t4_cpl_err", cpl_err, 1'b1);
    check("t4_cpl_cycles", cpl_cycles, 32'd50);
    check("t4_cpl_buf", cpl_buf, 2'd0);
    done_lat = 10;
    accept();
    wait_start(n);
    check("t4_next_buf", core_buf, 2'd1);
    wait_cpl(n);
    check("t4_next_err", cpl_err, 1'b0);
    check("t4_next_cycles", cpl_cycles, 32'd11);
    accept();
`endif

    // ap_rst mid-RUN with two requests queued
    done_lat = 1000;
    req_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      req_buf = 2'(i);
      tick();
    end
    req_valid = 1'b0;
    wait_start(n);
    repeat (5) tick();
    check("t5_pre_level", q_level, 3'd2);
    ap_rst = 1'b1;
    #1;
    check("t5_level",      q_level,    3'd0);
    check("t5_busy",       busy,       1'b0);
    check("t5_req_ready",  req_ready,  1'b1);
    check("t5_core_start", core_start, 1'b0);
    check("t5_core_rst",   core_rst,   1'b0);
    check("t5_core_key",   core_key,   6'h00);
    check("t5_core_buf",   core_buf,   2'd0);
    check("t5_cpl_valid",  cpl_valid,  1'b0);
    check("t5_cpl_cycles", cpl_cycles, 32'd0);
    check("t5_cpl_err",    cpl_err,    1'b0);
    repeat (2) tick();
    ap_rst = 1'b0;
    seen = 0;
    repeat (20) begin
      tick();
      if (cpl_valid || core_start) seen++;
    end
    check("t5_nothing_after_reset", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
